gavgunpool: RTL and testbench

GAVGUNPOOL -- requirements
Module: gavgunpool

---
 rtl/cnn1d_pkg.sv | 20 ++
 rtl/div.sv | 42 ++++
 rtl/gavgunpool.sv | 128 ++++++++++++
 tb/tb_gavgunpool.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn1d_pkg.sv
// Shared types and constant helpers for the 1-D CNN datapath blocks.
// No logic; imported by gavgunpool and its divider.
package cnn1d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_EMIT = 2'd2
    } gu_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div.sv
// Unsigned divider, quotient registered PIPE_WIDTH cycles after num/den are presented.
// Free-running pipeline with no backpressure; divide by zero returns all ones.
module div #(
    parameter int DATA_WIDTH = 12,
    parameter int PIPE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] num,
    input  logic [DATA_WIDTH-1:0] den,
    output logic [DATA_WIDTH-1:0] quo
);

    logic [DATA_WIDTH-1:0] pipe_d [PIPE_WIDTH];
    logic [DATA_WIDTH-1:0] pipe_q [PIPE_WIDTH];

    // The divide sits in front of the delay line so retiming can spread it across stages.
    always_comb begin
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        pipe_d[0] = (den == '0) ? '1 : (num / den);
        for (int i = 1; i < PIPE_WIDTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign quo = pipe_q[PIPE_WIDTH-1];

endmodule

// File: rtl/gavgunpool.sv
// Global-average unpool: one accepted sample becomes POOL_SIZE outputs (optionally divided by POOL_SIZE).
// First output 1 cycle (SCALE=0) or PIPE_WIDTH+1 cycles (SCALE=1) after accept; output holds under ready_out low.
module gavgunpool
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int POOL_SIZE  = 250,
    parameter int PIPE_WIDTH = 4,
    parameter int SCALE      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  gavgunpool_ready_in,
    input  logic                  gavgunpool_valid_in,
    input  logic [DATA_WIDTH-1:0] gavgunpool_data_in,
    input  logic                  gavgunpool_ready_out,
    output logic                  gavgunpool_valid_out,
    output logic [DATA_WIDTH-1:0] gavgunpool_data_out,
    output logic                  gavgunpool_last_out
);

    localparam int CNT_W  = (clog2(POOL_SIZE) > 0) ? clog2(POOL_SIZE) : 1;
    localparam int DCNT_W = clog2(PIPE_WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(POOL_SIZE - 1);
    localparam logic [DCNT_W-1:0] DIV_LAST = DCNT_W'(PIPE_WIDTH - 1);

    gu_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] quo;

    // The divider sees hold_d so its result lands exactly when DIV finishes.
    generate
        if (SCALE == 1) begin : g_div
            localparam logic [DATA_WIDTH-1:0] DENOM = DATA_WIDTH'(POOL_SIZE);
            div #(
                .DATA_WIDTH (DATA_WIDTH),
                .PIPE_WIDTH (PIPE_WIDTH)
            ) u_div (
                .clk (clk),
                .rst (rst),
                .num (hold_d),
                .den (DENOM),
                .quo (quo)
            );
        end else begin : g_nodiv
            assign quo = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        hold_d  = hold_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (gavgunpool_valid_in && ready_q) begin
                    hold_d = gavgunpool_data_in;
                    if (SCALE == 1) begin
                        state_d = ST_DIV;
                        dcnt_d  = '0;
                    end else begin
                        state_d = ST_EMIT;
                        out_d   = gavgunpool_data_in;
                    end
                end
            end
            ST_DIV: begin
                if (dcnt_q == DIV_LAST) begin
                    state_d = ST_EMIT;
                    out_d   = quo;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (gavgunpool_ready_out) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_EMIT);
        last_d  = (state_d == ST_EMIT) && (cnt_d == LAST_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign gavgunpool_ready_in  = ready_q;
    assign gavgunpool_valid_out = valid_q;
    assign gavgunpool_data_out  = out_q;
    assign gavgunpool_last_out  = last_q;

endmodule

// File: tb/tb_gavgunpool.sv
// Directed bench for gavgunpool: unit 0 replicates, unit 1 divides by 4, unit 2 has POOL_SIZE=1.
module tb_gavgunpool;

    logic        clk;
    logic        rst;
    logic [2:0]  rdy, vin, rout, vout, last;
    logic [11:0] din  [3];
    logic [11:0] dout [3];

    int checks;
    int errors;

    int          cap_lat, cap_n, cap_end;
    bit          cap_unstable, cap_rdy_at_last;
    logic [11:0] cap_data [8];
    logic        cap_last [8];

    gavgunpool #(.DATA_WIDTH(12), .POOL_SIZE(4), .PIPE_WIDTH(4), .SCALE(0)) u_rep (
        .clk(clk), .rst(rst),
        .gavgunpool_ready_in(rdy[0]), .gavgunpool_valid_in(vin[0]), .gavgunpool_data_in(din[0]),
        .gavgunpool_ready_out(rout[0]), .gavgunpool_valid_out(vout[0]),
        .gavgunpool_data_out(dout[0]), .gavgunpool_last_out(last[0])
    );

    gavgunpool #(.DATA_WIDTH(12), .POOL_SIZE(4), .PIPE_WIDTH(4), .SCALE(1)) u_avg (
        .clk(clk), .rst(rst),
        .gavgunpool_ready_in(rdy[1]), .gavgunpool_valid_in(vin[1]), .gavgunpool_data_in(din[1]),
        .gavgunpool_ready_out(rout[1]), .gavgunpool_valid_out(vout[1]),
        .gavgunpool_data_out(dout[1]), .gavgunpool_last_out(last[1])
    );

    gavgunpool #(.DATA_WIDTH(12), .POOL_SIZE(1), .PIPE_WIDTH(4), .SCALE(1)) u_one (
        .clk(clk), .rst(rst),
        .gavgunpool_ready_in(rdy[2]), .gavgunpool_valid_in(vin[2]), .gavgunpool_data_in(din[2]),
        .gavgunpool_ready_out(rout[2]), .gavgunpool_valid_out(vout[2]),
        .gavgunpool_data_out(dout[2]), .gavgunpool_last_out(last[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one sample to unit u; returns #1 after the accepting edge.
    task automatic do_accept(input int u, input logic [11:0] d);
        int t;
        t = 0;
        while (rdy[u] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rdy[u] !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready unit=%0d got=%b want=1 (timeout)", u, rdy[u]);
        end
        vin[u] = 1'b1;
        din[u] = d;
        @(posedge clk);
        #1;
        vin[u] = 1'b0;
    endtask

    // Observes one burst: latency in edges from accept to first transfer, data/last per transfer.
    task automatic capture(input int u, input logic [31:0] pat, input int plen,
                           input bit noise, input int stop_after);
        logic [11:0] prev_d;
        bit          prev_stall, xf, lf;
        cap_n = 0; cap_lat = -1; cap_end = -1; cap_unstable = 0; cap_rdy_at_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cap_data[i] = '0;
            cap_last[i] = 1'b0;
        end
        prev_d = '0;
        prev_stall = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            rout[u] = (cyc - 1 < plen) ? pat[cyc-1] : 1'b1;
            if (noise) begin
                vin[u] = 1'b1;
                din[u] = 12'(cyc * 37 + 5);
            end
            @(negedge clk);
            if (prev_stall && dout[u] !== prev_d) cap_unstable = 1;
            prev_stall = vout[u] && !rout[u];
            prev_d = dout[u];
            xf = vout[u] && rout[u];
            lf = last[u];
            if (xf) begin
                if (cap_n < 8) begin
                    cap_data[cap_n] = dout[u];
                    cap_last[cap_n] = last[u];
                end
                if (cap_lat < 0) cap_lat = cyc;
                cap_n++;
                cap_rdy_at_last = rdy[u];
            end
            @(posedge clk);
            #1;
            if (xf && (lf || cap_n == stop_after)) begin
                cap_end = cyc;
                break;
            end
        end
        vin[u] = 1'b0;
        rout[u] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (rdy[u] !== 1'b0) begin errors++; $display("FAIL reset_ready unit=%0d got=%b want=0", u, rdy[u]); end
            checks++;
            if (vout[u] !== 1'b0) begin errors++; $display("FAIL reset_valid unit=%0d got=%b want=0", u, vout[u]); end
            checks++;
            if (last[u] !== 1'b0) begin errors++; $display("FAIL reset_last unit=%0d got=%b want=0", u, last[u]); end
            checks++;
            if (dout[u] !== 12'h000) begin errors++; $display("FAIL reset_data unit=%0d got=%h want=000", u, dout[u]); end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (rdy[u] !== 1'b1) begin errors++; $display("FAIL reset_release_ready unit=%0d got=%b want=1", u, rdy[u]); end
        end
    endtask

    task automatic test_replicate;
        do_accept(0, 12'h123);
        capture(0, 32'h0, 0, 1'b0, 99);
        checks++;
        if (cap_lat !== 1) begin errors++; $display("FAIL rep_latency got=%0d want=1", cap_lat); end
        checks++;
        if (cap_n !== 4) begin errors++; $display("FAIL rep_count got=%0d want=4", cap_n); end
        checks++;
        if (cap_end !== 4) begin errors++; $display("FAIL rep_consecutive got_end=%0d want=4", cap_end); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 12'h123) begin errors++; $display("FAIL rep_data[%0d] got=%h want=123", i, cap_data[i]); end
            checks++;
            if (cap_last[i] !== (i == 3)) begin errors++; $display("FAIL rep_last[%0d] got=%b want=%b", i, cap_last[i], (i == 3)); end
        end
        checks++;
        if (cap_rdy_at_last !== 1'b0) begin errors++; $display("FAIL rep_no_same_cycle_ready got=%b want=0", cap_rdy_at_last); end
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rep_ready_after got=%b want=1", rdy[0]); end
        checks++;
        if (vout[0] !== 1'b0) begin errors++; $display("FAIL rep_valid_after got=%b want=0", vout[0]); end
    endtask

    task automatic test_divide;
        do_accept(1, 12'd1000);
        capture(1, 32'h0, 0, 1'b0, 99);
        checks++;
        if (cap_lat !== 5) begin errors++; $display("FAIL div_latency got=%0d want=5", cap_lat); end
        checks++;
        if (cap_n !== 4) begin errors++; $display("FAIL div_count got=%0d want=4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 12'd250) begin errors++; $display("FAIL div1000_data[%0d] got=%0d want=250", i, cap_data[i]); end
        end
        checks++;
        if (cap_last[3] !== 1'b1 || cap_last[2] !== 1'b0) begin
            errors++; $display("FAIL div_last got=%b%b want=01", cap_last[2], cap_last[3]);
        end
        do_accept(1, 12'd7);
        capture(1, 32'h0, 0, 1'b0, 99);
        checks++;
        if (cap_n !== 4) begin errors++; $display("FAIL div7_count got=%0d want=4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 12'd1) begin errors++; $display("FAIL div7_data[%0d] got=%0d want=1", i, cap_data[i]); end
        end
    endtask

    task automatic test_stall;
        // ready_out per cycle: 1,0,0,1,0,1,1 (bit 0 first)
        do_accept(0, 12'h2A5);
        capture(0, 32'h0000_0069, 7, 1'b0, 99);
        checks++;
        if (cap_n !== 4) begin errors++; $display("FAIL stall_count got=%0d want=4", cap_n); end
        checks++;
        if (cap_end !== 7) begin errors++; $display("FAIL stall_end_cycle got=%0d want=7", cap_end); end
        checks++;
        if (cap_unstable !== 1'b0) begin errors++; $display("FAIL stall_stable got=%b want=0", cap_unstable); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 12'h2A5 || cap_last[i] !== (i == 3)) begin
                errors++; $display("FAIL stall_xfer[%0d] got=%h/%b want=2a5/%b", i, cap_data[i], cap_last[i], (i == 3));
            end
        end
    endtask

    task automatic test_ignore_busy;
        do_accept(0, 12'h456);
        capture(0, 32'h0, 0, 1'b1, 99);
        checks++;
        if (cap_n !== 4) begin errors++; $display("FAIL ignore_count got=%0d want=4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 12'h456) begin errors++; $display("FAIL ignore_data[%0d] got=%h want=456", i, cap_data[i]); end
        end
        do_accept(0, 12'h3C3);
        capture(0, 32'h0, 0, 1'b0, 99);
        checks++;
        if (cap_n !== 4 || cap_data[0] !== 12'h3C3 || cap_data[3] !== 12'h3C3) begin
            errors++; $display("FAIL ignore_next_burst got=%0d/%h/%h want=4/3c3/3c3", cap_n, cap_data[0], cap_data[3]);
        end
    endtask

    task automatic test_reset_mid_burst;
        do_accept(0, 12'h777);
        capture(0, 32'h0, 0, 1'b0, 2);
        checks++;
        if (cap_n !== 2 || vout[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got=%0d/%b want=2/1", cap_n, vout[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (vout[0] !== 1'b0 || last[0] !== 1'b0 || dout[0] !== 12'h000 || rdy[0] !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got=v%b l%b d%h r%b want=v0 l0 d000 r0", vout[0], last[0], dout[0], rdy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", rdy[0]); end
        do_accept(0, 12'h0FF);
        capture(0, 32'h0, 0, 1'b0, 99);
        checks++;
        if (cap_n !== 4 || cap_lat !== 1) begin errors++; $display("FAIL midrst_burst got=%0d/%0d want=4/1", cap_n, cap_lat); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 12'h0FF || cap_last[i] !== (i == 3)) begin
                errors++; $display("FAIL midrst_xfer[%0d] got=%h/%b want=0ff/%b", i, cap_data[i], cap_last[i], (i == 3));
            end
        end
    endtask

    task automatic test_pool_one;
        do_accept(2, 12'hFFF);
        capture(2, 32'h0, 0, 1'b0, 99);
        checks++;
        if (cap_n !== 1) begin errors++; $display("FAIL pool1_count got=%0d want=1", cap_n); end
        checks++;
        if (cap_lat !== 5) begin errors++; $display("FAIL pool1_latency got=%0d want=5", cap_lat); end
        checks++;
        if (cap_data[0] !== 12'hFFF || cap_last[0] !== 1'b1) begin
            errors++; $display("FAIL pool1_xfer got=%h/%b want=fff/1", cap_data[0], cap_last[0]);
        end
        checks++;
        if (rdy[2] !== 1'b1) begin errors++; $display("FAIL pool1_ready_after got=%b want=1", rdy[2]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vin  = '0;
        rout = '0;
        for (int u = 0; u < 3; u++) din[u] = '0;
        test_reset();
        test_replicate();
        test_divide();
        test_stall();
        test_ignore_busy();
        test_reset_mid_burst();
        test_pool_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
